// File: rtl/pipe_fetch_ctrl_if.sv
// Fetch-stage bus bundle: pipeline control from ID, instruction ROM port, IF/ID register and debug read port.
// The fetch controller takes the master modport; the pipeline/ROM/debug environment takes the slave modport.
interface pipe_fetch_ctrl_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        dbg_req;
  logic [31:0] dbg_addr;
  logic        dbg_ack;
  logic [31:0] dbg_data;

  modport master (
    input  stall, redirect, redirect_pc, imem_inst, dbg_req, dbg_addr,
    output imem_addr, if_valid, if_inst, if_pc, if_pc4, dbg_ack, dbg_data
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_inst, dbg_req, dbg_addr,
    input  imem_addr, if_valid, if_inst, if_pc, if_pc4, dbg_ack, dbg_data
  );
endinterface

// File: rtl/pipe_fetch_ctrl.sv
// Instruction-fetch controller: PC, IF/ID register, delay-slot redirects, shared ROM port with a debug reader.
// Define PIPE_FETCH_DBG_EN to build the debug port and its stall-borrow / forced-steal arbiter.
module pipe_fetch_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned DBG_WAIT_MAX = 15
) (
  input logic              clock,
  input logic              reset,
  pipe_fetch_ctrl_if.master bus
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 8;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] target;
  logic            if_valid;
  logic [XLEN-1:0] if_inst;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_pc4;
  logic            steal_c;

  assign pc4    = pc + XLEN'(4);
  assign target = bus.redirect_pc & ~XLEN'(3);

`ifdef PIPE_FETCH_DBG_EN
  typedef enum logic [1:0] {D_IDLE, D_WAIT, D_ACK} dbg_state_e;

  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(DBG_WAIT_MAX);

  dbg_state_e      state;
  dbg_state_e      state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic            grant_c;
  logic            ack_c;
  logic [XLEN-1:0] dbg_data;

  // Arbiter state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= D_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Arbiter next state; the wait counter only runs while a request is pending and unserved
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      D_IDLE: begin
        if (bus.dbg_req) begin
          cnt_nxt   = '0;
          state_nxt = grant_c ? D_ACK : D_WAIT;
        end
      end
      D_WAIT: begin
        if (!bus.dbg_req) begin
          state_nxt = D_IDLE;
        end else if (grant_c) begin
          state_nxt = D_ACK;
        end else if (cnt != {CNT_W{1'b1}}) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      D_ACK:   state_nxt = D_IDLE;
      default: state_nxt = D_IDLE;
    endcase
  end

  // Arbiter outputs: stalls are borrowed freely, a steal never displaces a delay-slot fetch
  always_comb begin
    grant_c = 1'b0;
    ack_c   = 1'b0;
    case (state)
      D_IDLE:  grant_c = bus.dbg_req && bus.stall;
      D_WAIT:  grant_c = bus.dbg_req && (bus.stall || ((cnt >= WAIT_MAX) && !bus.redirect));
      D_ACK:   ack_c   = 1'b1;
      default: grant_c = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dbg_data <= '0;
    end else if (grant_c) begin
      dbg_data <= bus.imem_inst;
    end
  end

  assign steal_c       = grant_c && !bus.stall;
  assign bus.imem_addr = grant_c ? (bus.dbg_addr & ~XLEN'(3)) : pc;
  assign bus.dbg_ack   = ack_c;
  assign bus.dbg_data  = dbg_data;
`else
  assign steal_c       = 1'b0;
  assign bus.imem_addr = pc;
  assign bus.dbg_ack   = 1'b0;
  assign bus.dbg_data  = '0;
`endif

  // PC and IF/ID register: stall holds everything, a steal inserts one bubble
  always_ff @(posedge clock) begin
    if (reset) begin
      pc       <= RESET_PC;
      if_valid <= 1'b0;
      if_inst  <= '0;
      if_pc    <= '0;
      if_pc4   <= '0;
    end else if (bus.stall) begin
      pc       <= pc;
    end else if (steal_c) begin
      if_valid <= 1'b0;
    end else begin
      if_valid <= 1'b1;
      if_inst  <= bus.imem_inst;
      if_pc    <= pc;
      if_pc4   <= pc4;
      pc       <= bus.redirect ? target : pc4;
    end
  end

  assign bus.if_valid = if_valid;
  assign bus.if_inst  = if_inst;
  assign bus.if_pc    = if_pc;
  assign bus.if_pc4   = if_pc4;

endmodule
